// File: rtl/find_scheduler.sv
// Job scheduler for the exhaustive sequence search: enumerates candidates, dispatches them
// round-robin to the energy-evaluation units and tracks the minimum-energy result.
module find_scheduler #(
    parameter int unsigned SEQ_WIDTH      = 16,
    parameter int unsigned E_WIDTH        = 16,
    parameter int unsigned PARALLEL_UNITS = 2
) (
    input  logic                               wb_clk_i,
    input  logic                               wb_rst_i,
    input  logic                               start_i,
    input  logic                               abort_i,
    input  logic [SEQ_WIDTH-1:0]               seq_start_i,
    input  logic [SEQ_WIDTH:0]                 seq_count_i,
    output logic                               busy_o,
    output logic                               done_o,
    output logic                               aborted_o,
    output logic                               best_valid_o,
    output logic [SEQ_WIDTH-1:0]               best_seq_o,
    output logic [E_WIDTH-1:0]                 best_e_o,
    output logic [PARALLEL_UNITS-1:0]          unit_req_valid_o,
    output logic [SEQ_WIDTH-1:0]               unit_req_seq_o,
    input  logic [PARALLEL_UNITS-1:0]          unit_req_ready_i,
    input  logic [PARALLEL_UNITS-1:0]          unit_res_valid_i,
    input  logic [PARALLEL_UNITS*E_WIDTH-1:0]  unit_res_e_i
);

    localparam int unsigned N  = PARALLEL_UNITS;
    localparam int unsigned CW = SEQ_WIDTH + 1;
    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] MAX_COUNT = CW'(1) << SEQ_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                        state, state_n;
    logic [CW-1:0]                 count, count_n;
    logic [CW-1:0]                 issued, issued_n;
    logic [CW-1:0]                 completed, completed_n;
    logic [SEQ_WIDTH-1:0]          base, base_n;
    logic [PW-1:0]                 ptr, ptr_n;
    logic [N-1:0]                  outst, outst_n;
    logic [N-1:0][SEQ_WIDTH-1:0]   inflight, inflight_n;
    logic [N-1:0]                  req_valid, req_valid_n;
    logic [SEQ_WIDTH-1:0]          req_seq, req_seq_n;
    logic                          best_valid, best_valid_n;
    logic [SEQ_WIDTH-1:0]          best_seq, best_seq_n;
    logic [E_WIDTH-1:0]            best_e, best_e_n;
    logic                          aborted, aborted_n;
    logic                          busy, busy_n;
    logic                          done, done_n;

    logic [N-1:0]                  hs;
    logic [N-1:0]                  accepted;
    logic [CW-1:0]                 count_clamped;
    logic                          res_found;
    logic [E_WIDTH-1:0]            res_e;
    logic [SEQ_WIDTH-1:0]          res_seq;
    logic                          tgt_found;
    int                            tgt;
    int                            best_d;
    int                            d;
    logic [N-1:0]                  tgt_vec;

    assign count_clamped = (seq_count_i > MAX_COUNT) ? MAX_COUNT : seq_count_i;

    // Next-state, dispatch and best-result logic.
    always_comb begin
        state_n      = state;
        count_n      = count;
        issued_n     = issued;
        completed_n  = completed;
        base_n       = base;
        ptr_n        = ptr;
        outst_n      = outst;
        inflight_n   = inflight;
        req_valid_n  = req_valid;
        req_seq_n    = req_seq;
        best_valid_n = best_valid;
        best_seq_n   = best_seq;
        best_e_n     = best_e;
        aborted_n    = aborted;
        hs           = req_valid & unit_req_ready_i;
        accepted     = unit_res_valid_i & outst;
        res_found    = 1'b0;
        res_e        = '0;
        res_seq      = '0;
        tgt_found    = 1'b0;
        tgt          = 0;
        best_d       = int'(N);
        d            = 0;
        tgt_vec      = '0;

        // Retire results and record handshakes; strict < keeps the lowest index on ties.
        for (int k = 0; k < int'(N); k++) begin
            if (accepted[k]) begin
                outst_n[k]  = 1'b0;
                completed_n = completed_n + CW'(1);
                if (!res_found || (unit_res_e_i[k*E_WIDTH +: E_WIDTH] < res_e)) begin
                    res_found = 1'b1;
                    res_e     = unit_res_e_i[k*E_WIDTH +: E_WIDTH];
                    res_seq   = inflight[k];
                end
            end
            if (hs[k]) begin
                outst_n[k]    = 1'b1;
                inflight_n[k] = req_seq;
                issued_n      = issued + CW'(1);
                ptr_n         = PW'((k + 1) % int'(N));
            end
        end

        if (res_found && (!best_valid || (res_e < best_e))) begin
            best_valid_n = 1'b1;
            best_e_n     = res_e;
            best_seq_n   = res_seq;
        end

        // First free unit at or after the (updated) round-robin pointer.
        for (int k = 0; k < int'(N); k++) begin
            d = (k + int'(N) - int'(ptr_n)) % int'(N);
            if (!outst_n[k] && (d < best_d)) begin
                best_d    = d;
                tgt       = k;
                tgt_found = 1'b1;
            end
        end
        for (int k = 0; k < int'(N); k++) begin
            tgt_vec[k] = tgt_found && (k == tgt);
        end

        case (state)
            IDLE: begin
                if (start_i) begin
                    state_n      = RUN;
                    base_n       = seq_start_i;
                    count_n      = count_clamped;
                    issued_n     = '0;
                    completed_n  = '0;
                    best_valid_n = 1'b0;
                    best_seq_n   = '0;
                    best_e_n     = '0;
                    aborted_n    = 1'b0;
                    req_valid_n  = '0;
                    if (count_clamped != '0) begin
                        req_valid_n = tgt_vec;
                        req_seq_n   = seq_start_i;
                    end
                end
            end
            RUN: begin
                if ((completed_n == count) && (outst_n == '0)) begin
                    state_n     = DONE;
                    req_valid_n = '0;
                end else if (abort_i) begin
                    state_n     = DRAIN;
                    req_valid_n = '0;
                end else if ((req_valid == '0) || (hs != '0)) begin
                    // A pending request holds until accepted; otherwise look for the next slot.
                    req_valid_n = '0;
                    if ((issued_n < count) && tgt_found) begin
                        req_valid_n = tgt_vec;
                        req_seq_n   = base + SEQ_WIDTH'(issued_n);
                    end
                end
            end
            DRAIN: begin
                req_valid_n = '0;
                if (outst_n == '0) begin
                    state_n   = DONE;
                    aborted_n = 1'b1;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        busy_n = (state_n == RUN) || (state_n == DRAIN);
        done_n = (state_n == DONE);
    end

    // State register with synchronous reset.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state      <= IDLE;
            count      <= '0;
            issued     <= '0;
            completed  <= '0;
            base       <= '0;
            ptr        <= '0;
            outst      <= '0;
            inflight   <= '0;
            req_valid  <= '0;
            req_seq    <= '0;
            best_valid <= 1'b0;
            best_seq   <= '0;
            best_e     <= '0;
            aborted    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            count      <= count_n;
            issued     <= issued_n;
            completed  <= completed_n;
            base       <= base_n;
            ptr        <= ptr_n;
            outst      <= outst_n;
            inflight   <= inflight_n;
            req_valid  <= req_valid_n;
            req_seq    <= req_seq_n;
            best_valid <= best_valid_n;
            best_seq   <= best_seq_n;
            best_e     <= best_e_n;
            aborted    <= aborted_n;
            busy       <= busy_n;
            done       <= done_n;
        end
    end

    assign busy_o           = busy;
    assign done_o           = done;
    assign aborted_o        = aborted;
    assign best_valid_o     = best_valid;
    assign best_seq_o       = best_seq;
    assign best_e_o         = best_e;
    assign unit_req_valid_o = req_valid;
    assign unit_req_seq_o   = req_seq;

endmodule

// File: tb/tb_find_scheduler.sv
// Self-checking bench for find_scheduler: table-driven runs against fixed-latency unit
// models, plus directed backpressure, reset and abort sequences.
module tb_find_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [15:0] seq_start;
    logic [16:0] seq_count;
    logic        busy_o, done_o, aborted_o, best_valid_o;
    logic [15:0] best_seq_o, best_e_o, unit_req_seq_o;
    logic [1:0]  unit_req_valid_o;
    logic [1:0]  rdy;
    logic [1:0]  res_v;
    logic [31:0] res_e;

    always #5 clk = ~clk;

    find_scheduler #(.SEQ_WIDTH(16), .E_WIDTH(16), .PARALLEL_UNITS(2)) dut (
        .wb_clk_i         (clk),
        .wb_rst_i         (rst),
        .start_i          (start),
        .abort_i          (abort),
        .seq_start_i      (seq_start),
        .seq_count_i      (seq_count),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .aborted_o        (aborted_o),
        .best_valid_o     (best_valid_o),
        .best_seq_o       (best_seq_o),
        .best_e_o         (best_e_o),
        .unit_req_valid_o (unit_req_valid_o),
        .unit_req_seq_o   (unit_req_seq_o),
        .unit_req_ready_i (rdy),
        .unit_res_valid_i (res_v),
        .unit_res_e_i     (res_e)
    );

    typedef struct {
        logic [15:0] start;
        logic [16:0] count;
        int          lat0;
        int          lat1;
        logic [15:0] e0, e1, e2, e3;
        logic        bv;
        logic [15:0] bseq;
        logic [15:0] be;
        int          dlat;
    } vec_t;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    int          lat [2];
    logic        pv [2];
    logic [15:0] pseq [2];
    int          pdue [2];
    logic [15:0] etab [4];
    logic        use_tab;
    logic [15:0] run_base;
    logic [15:0] log_seq [$];
    int          log_unit [$];
    vec_t        tbl [5];

    function automatic logic [15:0] energy(input logic [15:0] s);
        logic [15:0] off;
        off = s - run_base;
        if (use_tab && (off < 16'd4)) return etab[off[1:0]];
        return 16'h1000 + {4'h0, s[11:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: log handshakes, advance, then drive any due unit results.
    task automatic step();
        for (int k = 0; k < 2; k++) begin
            if ((unit_req_valid_o[k] === 1'b1) && rdy[k]) begin
                log_seq.push_back(unit_req_seq_o);
                log_unit.push_back(k);
                pv[k]   = 1'b1;
                pseq[k] = unit_req_seq_o;
                pdue[k] = cyc + lat[k];
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        res_v = 2'b00;
        res_e = '0;
        for (int k = 0; k < 2; k++) begin
            if (pv[k] && (pdue[k] == cyc)) begin
                res_v[k]           = 1'b1;
                res_e[k*16 +: 16]  = energy(pseq[k]);
                pv[k]              = 1'b0;
            end
        end
        if (done_o === 1'b1) done_cnt++;
    endtask

    task automatic kick(input logic [15:0] s, input logic [16:0] c);
        seq_start = s;
        seq_count = c;
        run_base  = s;
        log_seq.delete();
        log_unit.delete();
        done_cnt  = 0;
        start     = 1'b1;
        step();
        start     = 1'b0;
    endtask

    task automatic wait_done(input int n0, output int n);
        n = n0;
        while ((done_o !== 1'b1) && (n < 300)) begin
            step();
            n++;
        end
        if (done_o !== 1'b1) chk("done_timeout", {31'd0, done_o}, 32'd1);
    endtask

    initial begin
        int          n;
        logic [15:0] exp_seq;

        tbl[0] = '{16'h0010, 17'd4, 3, 3, 16'h0050, 16'h0020, 16'h0030, 16'h0020, 1'b1, 16'h0011, 16'h0020, 10};
        tbl[1] = '{16'hFFFE, 17'd4, 3, 3, 16'h0009, 16'h0008, 16'h0007, 16'h0006, 1'b1, 16'h0001, 16'h0006, 10};
        tbl[2] = '{16'h0020, 17'd0, 3, 3, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 1'b0, 16'h0000, 16'h0000, 2};
        tbl[3] = '{16'h0100, 17'd4, 3, 2, 16'h0007, 16'h0007, 16'h0007, 16'h0007, 1'b1, 16'h0100, 16'h0007, 9};
        tbl[4] = '{16'h0200, 17'd2, 3, 2, 16'h0009, 16'h0005, 16'h0000, 16'h0000, 1'b1, 16'h0201, 16'h0005, 5};

        rst = 1'b1; start = 1'b0; abort = 1'b0; seq_start = '0; seq_count = '0;
        rdy = 2'b11; res_v = 2'b00; res_e = '0; use_tab = 1'b0; run_base = '0;
        lat[0] = 3; lat[1] = 3; pv[0] = 1'b0; pv[1] = 1'b0; pdue[0] = 0; pdue[1] = 0;
        pseq[0] = '0; pseq[1] = '0;
        step();
        step();
        rst = 1'b0;
        chk("rst_busy", {31'd0, busy_o}, 0);
        chk("rst_done", {31'd0, done_o}, 0);
        chk("rst_aborted", {31'd0, aborted_o}, 0);
        chk("rst_best_valid", {31'd0, best_valid_o}, 0);
        chk("rst_best_seq", {16'd0, best_seq_o}, 0);
        chk("rst_best_e", {16'd0, best_e_o}, 0);
        chk("rst_req_valid", {30'd0, unit_req_valid_o}, 0);
        chk("rst_req_seq", {16'd0, unit_req_seq_o}, 0);

        // Table-driven complete runs.
        for (int i = 0; i < 5; i++) begin
            lat[0] = tbl[i].lat0; lat[1] = tbl[i].lat1;
            etab[0] = tbl[i].e0; etab[1] = tbl[i].e1; etab[2] = tbl[i].e2; etab[3] = tbl[i].e3;
            use_tab = 1'b1;
            kick(tbl[i].start, tbl[i].count);
            wait_done(1, n);
            chk($sformatf("c%0d_done_lat", i), n, tbl[i].dlat);
            chk($sformatf("c%0d_busy_at_done", i), {31'd0, busy_o}, 0);
            chk($sformatf("c%0d_best_valid", i), {31'd0, best_valid_o}, {31'd0, tbl[i].bv});
            if (tbl[i].bv) begin
                chk($sformatf("c%0d_best_seq", i), {16'd0, best_seq_o}, {16'd0, tbl[i].bseq});
                chk($sformatf("c%0d_best_e", i), {16'd0, best_e_o}, {16'd0, tbl[i].be});
            end
            chk($sformatf("c%0d_aborted", i), {31'd0, aborted_o}, 0);
            chk($sformatf("c%0d_n_dispatch", i), log_seq.size(), {15'd0, tbl[i].count});
            for (int j = 0; j < log_seq.size(); j++) begin
                exp_seq = tbl[i].start + 16'(j);
                chk($sformatf("c%0d_disp%0d_seq", i, j), {16'd0, log_seq[j]}, {16'd0, exp_seq});
                chk($sformatf("c%0d_disp%0d_unit", i, j), log_unit[j], j % 2);
            end
            step();
            chk($sformatf("c%0d_done_pulse", i), {31'd0, done_o}, 0);
            chk($sformatf("c%0d_done_count", i), done_cnt, 1);
        end

        // Backpressure: unit 0 stalls for five cycles.
        use_tab = 1'b0; lat[0] = 3; lat[1] = 3;
        rdy = 2'b10;
        kick(16'h0300, 17'd3);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_valid%0d", i), {30'd0, unit_req_valid_o}, 32'd1);
            chk($sformatf("bp_seq%0d", i), {16'd0, unit_req_seq_o}, 32'h0300);
            step();
        end
        rdy = 2'b11;
        wait_done(6, n);
        chk("bp_done_lat", n, 14);
        chk("bp_n_dispatch", log_seq.size(), 3);
        for (int j = 0; j < log_seq.size(); j++) begin
            exp_seq = 16'h0300 + 16'(j);
            chk($sformatf("bp_disp%0d_seq", j), {16'd0, log_seq[j]}, {16'd0, exp_seq});
            chk($sformatf("bp_disp%0d_unit", j), log_unit[j], j % 2);
        end
        chk("bp_best_seq", {16'd0, best_seq_o}, 32'h0300);
        chk("bp_best_e", {16'd0, best_e_o}, 32'h1300);
        step();

        // Reset in the middle of a run; stale results must be ignored.
        kick(16'h0500, 17'd10);
        for (int i = 0; i < 4; i++) step();
        chk("mr_best_valid_before", {31'd0, best_valid_o}, 1);
        chk("mr_busy_before", {31'd0, busy_o}, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mr_busy", {31'd0, busy_o}, 0);
        chk("mr_done", {31'd0, done_o}, 0);
        chk("mr_aborted", {31'd0, aborted_o}, 0);
        chk("mr_best_valid", {31'd0, best_valid_o}, 0);
        chk("mr_best_seq", {16'd0, best_seq_o}, 0);
        chk("mr_best_e", {16'd0, best_e_o}, 0);
        chk("mr_req_valid", {30'd0, unit_req_valid_o}, 0);
        chk("mr_req_seq", {16'd0, unit_req_seq_o}, 0);
        for (int i = 0; i < 6; i++) step();
        chk("mr_stale_best_valid", {31'd0, best_valid_o}, 0);
        chk("mr_stale_best_e", {16'd0, best_e_o}, 0);
        chk("mr_stale_busy", {31'd0, busy_o}, 0);
        chk("mr_stale_done_count", done_cnt, 0);

        // Abort with a pending request on unit 1, plus a start during DRAIN.
        rdy = 2'b01;
        kick(16'h0400, 17'd100);
        chk("ab_valid_t1", {30'd0, unit_req_valid_o}, 32'd1);
        chk("ab_seq_t1", {16'd0, unit_req_seq_o}, 32'h0400);
        step();
        chk("ab_valid_t2", {30'd0, unit_req_valid_o}, 32'd2);
        chk("ab_seq_t2", {16'd0, unit_req_seq_o}, 32'h0401);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("ab_valid_dropped", {30'd0, unit_req_valid_o}, 0);
        chk("ab_busy_drain", {31'd0, busy_o}, 1);
        chk("ab_done_early", {31'd0, done_o}, 0);
        seq_start = 16'h0777; seq_count = 17'd5; start = 1'b1;
        step();
        start = 1'b0;
        chk("ab_busy_t4", {31'd0, busy_o}, 1);
        wait_done(4, n);
        chk("ab_done_lat", n, 5);
        chk("ab_aborted", {31'd0, aborted_o}, 1);
        chk("ab_best_valid", {31'd0, best_valid_o}, 1);
        chk("ab_best_seq", {16'd0, best_seq_o}, 32'h0400);
        chk("ab_best_e", {16'd0, best_e_o}, 32'h1400);
        chk("ab_n_dispatch", log_seq.size(), 1);
        chk("ab_disp0_unit", log_unit[0], 0);
        step();
        chk("ab_idle_busy", {31'd0, busy_o}, 0);
        chk("ab_idle_valid", {30'd0, unit_req_valid_o}, 0);
        chk("ab_aborted_hold", {31'd0, aborted_o}, 1);
        chk("ab_best_hold", {16'd0, best_seq_o}, 32'h0400);
        rdy = 2'b11;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
